// File: rtl/sig_mem_arbiter_if.sv
// Bus bundle between the signal-memory arbiter, its two requesters and the memory.
// The slave modport is the arbiter's view; master is the requester/memory side.
interface sig_mem_arbiter_if #(
    parameter int ADDR_WIDTH  = 12,
    parameter int DATA_WIDTH  = 32,
    parameter int WFIFO_DEPTH = 4
);
    localparam int CNT_W = $clog2(WFIFO_DEPTH) + 1;

    logic                  rd_req;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  rd_gnt;
    logic                  rd_valid;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  wr_req;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_ready;
    logic [CNT_W-1:0]      wr_count;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  mem_wen;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport slave (
        input  rd_req, rd_addr, wr_req, wr_addr, wr_data, mem_rdata,
        output rd_gnt, rd_valid, rd_data, wr_ready, wr_count, mem_addr, mem_wdata, mem_wen
    );

    modport master (
        output rd_req, rd_addr, wr_req, wr_addr, wr_data, mem_rdata,
        input  rd_gnt, rd_valid, rd_data, wr_ready, wr_count, mem_addr, mem_wdata, mem_wen
    );
endinterface

// File: rtl/sig_mem_arbiter.sv
// Single-port signal memory arbiter: display reads win, sample writes are queued
// in a small FIFO and drained on idle cycles, on starvation, or on a read hazard.
module sig_mem_arbiter #(
    parameter int ADDR_WIDTH   = 12,
    parameter int DATA_WIDTH   = 32,
    parameter int WFIFO_DEPTH  = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    sig_mem_arbiter_if.slave  bus
);
    localparam int PTR_W = $clog2(WFIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int STV_W = $clog2(STARVE_LIMIT) + 1;

    logic [ADDR_WIDTH-1:0]  r_fifo_addr [WFIFO_DEPTH];
    logic [DATA_WIDTH-1:0]  r_fifo_data [WFIFO_DEPTH];
    logic [WFIFO_DEPTH-1:0] r_vld;
    logic [PTR_W-1:0]       r_wptr;
    logic [PTR_W-1:0]       r_rptr;
    logic [CNT_W-1:0]       r_count;
    logic                   r_wr_ready;
    logic                   r_rd_valid;
    logic [STV_W-1:0]       r_starve;

    logic                   w_nonempty;
    logic                   w_addr_match;
    logic                   w_hazard;
    logic                   w_force;
    logic                   w_wr_issue;
    logic                   w_rd_issue;
    logic                   w_push;
    logic [CNT_W-1:0]       w_count_next;

    // Any queued entry (head included) aliasing the read address blocks the read.
    always_comb begin
        w_addr_match = 1'b0;
        for (int i = 0; i < WFIFO_DEPTH; i++) begin
            if (r_vld[i] && (r_fifo_addr[i] == bus.rd_addr)) begin
                w_addr_match = 1'b1;
            end
        end
    end

    assign w_hazard     = bus.rd_req && w_addr_match;
    assign w_nonempty   = (r_count != '0);
    assign w_force      = w_nonempty && (w_hazard || (r_starve >= STV_W'(STARVE_LIMIT)));
    assign w_wr_issue   = !i_rst && (w_force || (!bus.rd_req && w_nonempty));
    assign w_rd_issue   = !i_rst && !w_force && bus.rd_req;
    assign w_push       = bus.wr_req && r_wr_ready;
    assign w_count_next = r_count + CNT_W'(w_push) - CNT_W'(w_wr_issue);

    assign bus.rd_gnt    = w_rd_issue;
    assign bus.rd_valid  = r_rd_valid;
    assign bus.rd_data   = bus.mem_rdata;
    assign bus.wr_ready  = r_wr_ready;
    assign bus.wr_count  = r_count;
    assign bus.mem_wen   = w_wr_issue;
    assign bus.mem_addr  = w_wr_issue ? r_fifo_addr[r_rptr] : (w_rd_issue ? bus.rd_addr : '0);
    assign bus.mem_wdata = w_wr_issue ? r_fifo_data[r_rptr] : '0;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < WFIFO_DEPTH; i++) begin
                r_fifo_addr[i] <= '0;
                r_fifo_data[i] <= '0;
            end
            r_vld      <= '0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_wr_ready <= 1'b1;
            r_rd_valid <= 1'b0;
            r_starve   <= '0;
        end else begin
            // Push and pop never target the same slot: that needs empty or full.
            if (w_push) begin
                r_fifo_addr[r_wptr] <= bus.wr_addr;
                r_fifo_data[r_wptr] <= bus.wr_data;
                r_vld[r_wptr]       <= 1'b1;
                r_wptr              <= r_wptr + 1'b1;
            end
            if (w_wr_issue) begin
                r_vld[r_rptr] <= 1'b0;
                r_rptr        <= r_rptr + 1'b1;
            end
            r_count    <= w_count_next;
            r_wr_ready <= (w_count_next < CNT_W'(WFIFO_DEPTH));
            r_rd_valid <= w_rd_issue;
            if (w_wr_issue || !w_nonempty) begin
                r_starve <= '0;
            end else if (w_rd_issue && (r_starve < STV_W'(STARVE_LIMIT))) begin
                r_starve <= r_starve + 1'b1;
            end
        end
    end
endmodule
